// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for a MIPS-style pipeline.
//   A shadow copy of the producer instructions from EX onward is kept here.
//   Each source operand of the instruction in ID is resolved against that copy.
//   The result is a registered forwarding select for the cycle the instruction sits in EX.
//   A combinational stall is raised when a load result is not yet available.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset
//   id_valid     ID holds a real instruction
//   id_src       NSRC packed source addresses, operand i at [i*ADDR_W +: ADDR_W]
//   id_src_used  per-operand "actually read" mask
//   id_dest      ID destination register
//   id_regwrite  ID instruction writes a register
//   id_is_load   ID instruction is a load
//   flush        squash the ID instruction
//   stall        combinational: hold PC/IF/ID, insert a bubble into EX
//   fwd_sel      registered per-operand select (0 = regfile, j = pipeline reg j)
//   stall_count  saturating count of stall cycles
module fwd_hazard_unit #(
  parameter int NSRC       = 3,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NSRC*ADDR_W-1:0]  id_src,
  input  logic [NSRC-1:0]         id_src_used,
  input  logic [ADDR_W-1:0]       id_dest,
  input  logic                    id_regwrite,
  input  logic                    id_is_load,
  input  logic                    flush,
  output logic                    stall,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]        stall_count
);

  // Shadow entries; index p is the producer that will sit in pipeline register p+1 next.
  logic              valid_reg    [DEPTH];
  logic              regwrite_reg [DEPTH];
  logic [ADDR_W-1:0] dest_reg     [DEPTH];
  logic              is_load_reg  [DEPTH];

  logic [NSRC*SEL_W-1:0] cand_sel;
  logic [NSRC-1:0]       op_late;
  logic                  issue;

  genvar gi;

  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_op
      logic [ADDR_W-1:0] src;
      logic [SEL_W-1:0]  sel_c;
      logic              late_c;

      assign src = id_src[gi*ADDR_W +: ADDR_W];

      // Scan oldest to youngest so the youngest matching producer overwrites older ones.
      always_comb begin
        sel_c  = '0;
        late_c = 1'b0;
        for (int p = DEPTH - 1; p >= 0; p--) begin
          if (id_src_used[gi] && valid_reg[p] && regwrite_reg[p] &&
              (dest_reg[p] != '0) && (dest_reg[p] == src)) begin
            sel_c  = SEL_W'(p + 1);
            late_c = is_load_reg[p] && ((p + 1) < LOAD_READY);
          end
        end
      end

      assign cand_sel[gi*SEL_W +: SEL_W] = sel_c;
      assign op_late[gi]                 = late_c;
    end
  endgenerate

  // A squashed instruction never stalls; a bubble in ID never stalls.
  assign stall = id_valid & ~flush & (|op_late);
  assign issue = id_valid & ~stall & ~flush;

  // Entry 0 captures the issuing instruction or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg[0]    <= 1'b0;
      regwrite_reg[0] <= 1'b0;
      dest_reg[0]     <= '0;
      is_load_reg[0]  <= 1'b0;
    end else begin
      valid_reg[0]    <= issue;
      regwrite_reg[0] <= issue & id_regwrite;
      dest_reg[0]     <= id_dest;
      is_load_reg[0]  <= issue & id_is_load;
    end
  end

  // Older entries simply age by one stage; the last one falls off.
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi]    <= 1'b0;
          regwrite_reg[gi] <= 1'b0;
          dest_reg[gi]     <= '0;
          is_load_reg[gi]  <= 1'b0;
        end else begin
          valid_reg[gi]    <= valid_reg[gi-1];
          regwrite_reg[gi] <= regwrite_reg[gi-1];
          dest_reg[gi]     <= dest_reg[gi-1];
          is_load_reg[gi]  <= is_load_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_sel     <= '0;
      stall_count <= '0;
    end else begin
      fwd_sel <= issue ? cand_sel : '0;
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (default, and DEPTH=3/LOAD_READY=3/CNT_W=2)
// share one stimulus stream; each is compared every cycle against an age-based model.
module tb_fwd_hazard_unit;

  localparam int NSRC = 3;
  localparam int AW   = 5;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0] id_src_used;
  logic [AW-1:0] id_dest;
  logic id_regwrite;
  logic id_is_load;
  logic flush;

  logic stall0, stall1;
  logic [NSRC*SW-1:0] sel0, sel1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .flush(flush), .stall(stall0), .fwd_sel(sel0),
    .stall_count(cnt0)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_READY(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .flush(flush), .stall(stall1), .fwd_sel(sel1),
    .stall_count(cnt1)
  );

  // Model: history of issued instructions by age in cycles (age a = pipeline register a).
  int          m_depth   [2] = '{2, 3};
  int          m_lr      [2] = '{2, 3};
  int          m_cnt_max [2] = '{65535, 3};
  bit          h_v    [2][1:3];
  bit          h_rw   [2][1:3];
  logic [4:0]  h_dest [2][1:3];
  bit          h_ld   [2][1:3];
  logic [5:0]  m_sel  [2];
  int          m_cnt  [2];

  // Returns {stall, candidate selects} for instance k from current history and ID inputs.
  function automatic logic [6:0] model_eval(int k);
    logic       need;
    logic [5:0] sel;
    logic [4:0] s;
    bit         found;
    need = 1'b0;
    sel  = '0;
    for (int i = 0; i < NSRC; i++) begin
      s = id_src[i*AW +: AW];
      found = 1'b0;
      if (id_src_used[i]) begin
        for (int a = 1; a <= m_depth[k]; a++) begin
          if (!found && h_v[k][a] && h_rw[k][a] && h_dest[k][a] != 5'd0 && h_dest[k][a] == s) begin
            found = 1'b1;
            sel[i*SW +: SW] = 2'(a);
            if (h_ld[k][a] && a < m_lr[k]) need = 1'b1;
          end
        end
      end
    end
    return {id_valid && !flush && need, sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic update_model();
    logic [6:0] ev;
    bit issue;
    for (int k = 0; k < 2; k++) begin
      ev = model_eval(k);
      if (reset) begin
        for (int a = 1; a <= 3; a++) h_v[k][a] = 1'b0;
        m_sel[k] = '0;
        m_cnt[k] = 0;
      end else begin
        if (ev[6] && m_cnt[k] < m_cnt_max[k]) m_cnt[k]++;
        issue = id_valid && !ev[6] && !flush;
        for (int a = m_depth[k]; a >= 2; a--) begin
          h_v[k][a]    = h_v[k][a-1];
          h_rw[k][a]   = h_rw[k][a-1];
          h_dest[k][a] = h_dest[k][a-1];
          h_ld[k][a]   = h_ld[k][a-1];
        end
        h_v[k][1]    = issue;
        h_rw[k][1]   = id_regwrite;
        h_dest[k][1] = id_dest;
        h_ld[k][1]   = id_is_load;
        m_sel[k]     = issue ? ev[5:0] : 6'd0;
      end
    end
  endtask

  task automatic at_neg();
    logic [6:0] ev0, ev1;
    @(negedge clk);
    ev0 = model_eval(0);
    ev1 = model_eval(1);
    check("stall0", 32'(stall0), 32'(ev0[6]));
    check("sel0",   32'(sel0),   32'(m_sel[0]));
    check("cnt0",   32'(cnt0),   32'(m_cnt[0]));
    check("stall1", 32'(stall1), 32'(ev1[6]));
    check("sel1",   32'(sel1),   32'(m_sel[1]));
    check("cnt1",   32'(cnt1),   32'(m_cnt[1]));
  endtask

  task automatic adv();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input int s2, input int used,
                       input int dest, input bit rw, input bit ld, input bit fl, input bit rst);
    id_valid    = v;
    id_src      = {5'(s2), 5'(s1), 5'(s0)};
    id_src_used = 3'(used);
    id_dest     = 5'(dest);
    id_regwrite = rw;
    id_is_load  = ld;
    flush       = fl;
    reset       = rst;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    adv(); adv();
    // reset state
    at_neg();
    check("rst_stall0", 32'(stall0), 0); check("rst_sel0", 32'(sel0), 0); check("rst_cnt0", 32'(cnt0), 0);
    check("rst_stall1", 32'(stall1), 0); check("rst_sel1", 32'(sel1), 0); check("rst_cnt1", 32'(cnt1), 0);
    adv();
    // add $3 then sub reading $3
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); at_neg(); adv();
    drive(1, 3, 0, 0, 1, 7, 1, 0, 0, 0); at_neg(); check("alu_nostall", 32'(stall0), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_neg();
    check("alu_sel0", 32'(sel0), 1); check("alu_sel1", 32'(sel1), 1); adv();
    // lw $5 then add reading $5 as src1
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); at_neg(); check("pre_lw_sel0", 32'(sel0), 0); adv();
    drive(1, 0, 5, 0, 2, 8, 1, 0, 0, 0); at_neg();
    check("lu_stall0", 32'(stall0), 1); check("lu_stall1", 32'(stall1), 1); adv();
    at_neg();
    check("lu_release0", 32'(stall0), 0); check("lu_bubble0", 32'(sel0), 0);
    check("lu_cnt0", 32'(cnt0), 1); check("lu_stall1b", 32'(stall1), 1); adv();
    at_neg();
    check("lu_sel0", 32'(sel0), 8); check("lu_release1", 32'(stall1), 0); check("lu_cnt1", 32'(cnt1), 2); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_neg();
    check("lu_sel1", 32'(sel1), 12); check("aged_sel0", 32'(sel0), 0); adv();
    // youngest producer wins
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); at_neg(); adv();
    at_neg(); adv();
    drive(1, 4, 4, 0, 7, 9, 1, 0, 0, 0); at_neg();
    check("yw_stall0", 32'(stall0), 0); check("yw_stall1", 32'(stall1), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_neg();
    check("yw_sel0", 32'(sel0), 5); check("yw_sel1", 32'(sel1), 5); adv();
    // dest $0 producer, unused matching operand
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); at_neg(); adv();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); at_neg(); adv();
    drive(1, 0, 4, 0, 1, 10, 1, 0, 0, 0); at_neg();
    check("unused_stall0", 32'(stall0), 0); check("unused_stall1", 32'(stall1), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_neg();
    check("r0_sel0", 32'(sel0), 0); check("r0_sel1", 32'(sel1), 0); adv();
    // flush against a load in EX
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); at_neg(); adv();
    drive(1, 6, 0, 0, 1, 10, 1, 0, 1, 0); at_neg();
    check("fl_stall0", 32'(stall0), 0); check("fl_stall1", 32'(stall1), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_neg();
    check("fl_sel0", 32'(sel0), 0); check("fl_sel1", 32'(sel1), 0); adv();
    // counter saturation on the CNT_W=2 instance
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); at_neg(); adv();
    drive(1, 6, 0, 0, 1, 10, 1, 0, 0, 0); at_neg();
    check("sat_stall0", 32'(stall0), 1); check("sat_stall1", 32'(stall1), 1); adv();
    at_neg(); check("sat_cnt1a", 32'(cnt1), 3); check("sat_stall1b", 32'(stall1), 1); adv();
    at_neg(); check("sat_cnt1b", 32'(cnt1), 3); check("sat_release1", 32'(stall1), 0); adv();
    // reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); at_neg(); adv();
    drive(1, 6, 0, 0, 1, 10, 1, 0, 0, 1); at_neg();
    check("mr_stall0", 32'(stall0), 1); check("mr_stall1", 32'(stall1), 1); adv();
    drive(1, 6, 0, 0, 1, 10, 1, 0, 0, 0); at_neg();
    check("mr_stall0b", 32'(stall0), 0); check("mr_stall1b", 32'(stall1), 0);
    check("mr_sel0", 32'(sel0), 0); check("mr_sel1", 32'(sel1), 0);
    check("mr_cnt0", 32'(cnt0), 0); check("mr_cnt1", 32'(cnt1), 0); adv();

    // randomized traffic over a small register set so hazards are frequent
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 99) < 85,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 10, $urandom_range(0, 299) == 0);
      at_neg();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
